// File: rtl/end_frame_ctrl.sv
// End-of-round sequencer: freeze, fade out, show end screen, wait for a key, request restart.
// Optional feature: define ENDFRAME_AUTO_RESTART_EN to also leave WAIT_KEY after AUTO_RESTART_FRAMES ticks.
module end_frame_ctrl #(
    parameter int FREEZE_FRAMES       = 30,
    parameter int FADE_STEP_FRAMES    = 4,
    parameter int KEY_LOCKOUT_FRAMES  = 60,
    parameter int AUTO_RESTART_FRAMES = 600
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_start,
    input  logic       i_game_over,
    input  logic       i_p1_win,
    input  logic       i_key_any,
    output logic       o_frame_sel,
    output logic       o_is_p1_win,
    output logic [3:0] o_fade_level,
    output logic       o_restart,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FREEZE   = 3'd1,
        FADE     = 3'd2,
        SHOW     = 3'd3,
        WAIT_KEY = 3'd4
    } state_e;

    // The tick counter is 10 bits, so every frame count must fit in it.
    if (FREEZE_FRAMES > 1023 || FADE_STEP_FRAMES > 1023 ||
        KEY_LOCKOUT_FRAMES > 1023 || AUTO_RESTART_FRAMES > 1023) begin : g_param_check
        $error("end_frame_ctrl: frame-count parameters must be at most 1023");
    end

    localparam logic [9:0] FREEZE_N = FREEZE_FRAMES[9:0];
    localparam logic [9:0] STEP_N   = FADE_STEP_FRAMES[9:0];
    localparam logic [9:0] LOCK_N   = KEY_LOCKOUT_FRAMES[9:0];

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       key_q;
    logic       sel_q, sel_d;
    logic       win_q, win_d;
    logic [3:0] fade_q, fade_d;
    logic       restart_q, restart_d;
    logic       busy_q, busy_d;

    logic       key_rise;
    logic [9:0] cnt_inc;
    logic       step_hit;
    logic       auto_hit;

    assign key_rise = i_key_any & ~key_q;
    assign cnt_inc  = cnt_q + 10'd1;
    assign step_hit = (state_q == FADE) && i_frame_start && (cnt_inc == STEP_N);

`ifdef ENDFRAME_AUTO_RESTART_EN
    assign auto_hit = i_frame_start && (cnt_inc == AUTO_RESTART_FRAMES[9:0]);
`else
    assign auto_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_q     <= 1'b0;
            sel_q     <= 1'b0;
            win_q     <= 1'b0;
            fade_q    <= '0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= i_key_any;
            sel_q     <= sel_d;
            win_q     <= win_d;
            fade_q    <= fade_d;
            restart_q <= restart_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = i_frame_start ? cnt_inc : cnt_q;
        case (state_q)
            IDLE: begin
                if (i_game_over) state_d = FREEZE;
            end
            FREEZE: begin
                if (i_frame_start && cnt_inc == FREEZE_N) state_d = FADE;
            end
            FADE: begin
                if (step_hit && fade_q == 4'hF) state_d = SHOW;
            end
            SHOW: begin
                if (i_frame_start && cnt_inc == LOCK_N) state_d = WAIT_KEY;
            end
            WAIT_KEY: begin
                // Key edge and timeout both lead to the same single exit.
                if (key_rise || auto_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Each fade step restarts the count so steps are evenly spaced.
        if (state_d != state_q || step_hit) cnt_d = '0;
    end

    always_comb begin
        sel_d     = sel_q;
        win_d     = win_q;
        fade_d    = fade_q;
        restart_d = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                sel_d  = 1'b0;
                fade_d = '0;
                if (i_game_over) win_d = i_p1_win;
            end
            FADE: begin
                if (step_hit) begin
                    if (fade_q == 4'hF) begin
                        sel_d  = 1'b1;
                        fade_d = '0;
                    end else begin
                        fade_d = fade_q + 4'd1;
                    end
                end
            end
            WAIT_KEY: begin
                if (state_d == IDLE) begin
                    restart_d = 1'b1;
                    sel_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign o_frame_sel  = sel_q;
    assign o_is_p1_win  = win_q;
    assign o_fade_level = fade_q;
    assign o_restart    = restart_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_end_frame_ctrl.sv
// Bench for end_frame_ctrl with FREEZE=2, FADE_STEP=1, LOCKOUT=3, AUTO=5.
module tb_end_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fs, go, win, key;
    logic       o_frame_sel, o_is_p1_win, o_restart, o_busy;
    logic [3:0] o_fade_level;

    always #5 clk = ~clk;

    end_frame_ctrl #(
        .FREEZE_FRAMES      (2),
        .FADE_STEP_FRAMES   (1),
        .KEY_LOCKOUT_FRAMES (3),
        .AUTO_RESTART_FRAMES(5)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_start(fs),
        .i_game_over  (go),
        .i_p1_win     (win),
        .i_key_any    (key),
        .o_frame_sel  (o_frame_sel),
        .o_is_p1_win  (o_is_p1_win),
        .o_fade_level (o_fade_level),
        .o_restart    (o_restart),
        .o_busy       (o_busy)
    );

    // Expected output word: {frame_sel, is_p1_win, fade_level[3:0], restart, busy}
    typedef struct {
        logic       fs;
        logic       go;
        logic       win;
        logic       key;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [7:0] pk(logic sel, logic pw, logic [3:0] fade, logic rs, logic busy);
        return {sel, pw, fade, rs, busy};
    endfunction

    function automatic logic [7:0] outs();
        return {o_frame_sel, o_is_p1_win, o_fade_level, o_restart, o_busy};
    endfunction

    task automatic add(logic f, logic g, logic w, logic k, logic [7:0] e);
        vec_t v;
        v.fs = f; v.go = g; v.win = w; v.key = k; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic cyc(logic f, logic g, logic w, logic k);
        fs = f; go = g; win = w; key = k;
        @(posedge clk);
        #1;
    endtask

    task automatic build_table();
        // Round 1: player 1 wins, key held from late FADE, noise on go/win during FADE.
        add(0, 1, 1, 0, pk(0, 1, 0, 0, 1));
        add(0, 0, 0, 0, pk(0, 1, 0, 0, 1));
        add(1, 0, 0, 0, pk(0, 1, 0, 0, 1));
        add(1, 0, 0, 0, pk(0, 1, 0, 0, 1));
        for (int k = 1; k <= 15; k++) begin
            add(1, (k == 4 || k == 9), k[0], (k >= 12), pk(0, 1, 4'(k), 0, 1));
            add(0, (k == 6), ~k[0], (k >= 12), pk(0, 1, 4'(k), 0, 1));
        end
        add(1, 0, 0, 1, pk(1, 1, 0, 0, 1));
        for (int t = 1; t <= 3; t++) add(1, 0, 0, 1, pk(1, 1, 0, 0, 1));
        add(0, 0, 0, 1, pk(1, 1, 0, 0, 1));
        add(1, 0, 0, 1, pk(1, 1, 0, 0, 1));
        add(0, 0, 0, 1, pk(1, 1, 0, 0, 1));
        add(0, 0, 0, 0, pk(1, 1, 0, 0, 1));
        add(1, 0, 0, 1, pk(0, 1, 0, 1, 0));
        add(0, 0, 0, 1, pk(0, 1, 0, 0, 0));
        add(0, 0, 0, 0, pk(0, 1, 0, 0, 0));
        add(0, 0, 0, 1, pk(0, 1, 0, 0, 0));
        add(0, 0, 0, 0, pk(0, 1, 0, 0, 0));
        // Round 2: player 2 wins, key tapped in SHOW, then no key in WAIT_KEY.
        add(0, 1, 0, 0, pk(0, 0, 0, 0, 1));
        add(1, 0, 1, 0, pk(0, 0, 0, 0, 1));
        add(1, 0, 1, 0, pk(0, 0, 0, 0, 1));
        for (int k = 1; k <= 15; k++) add(1, 0, 0, 0, pk(0, 0, 4'(k), 0, 1));
        add(1, 0, 0, 0, pk(1, 0, 0, 0, 1));
        add(0, 0, 0, 1, pk(1, 0, 0, 0, 1));
        add(0, 0, 0, 0, pk(1, 0, 0, 0, 1));
        for (int t = 1; t <= 3; t++) add(1, 0, 0, 0, pk(1, 0, 0, 0, 1));
`ifdef ENDFRAME_AUTO_RESTART_EN
        for (int t = 1; t <= 4; t++) add(1, 0, 0, 0, pk(1, 0, 0, 0, 1));
        add(1, 0, 0, 0, pk(0, 0, 0, 1, 0));
        add(1, 0, 0, 0, pk(0, 0, 0, 0, 0));
`else
        for (int t = 1; t <= 20; t++) add(1, 0, 0, 0, pk(1, 0, 0, 0, 1));
        add(0, 0, 0, 1, pk(0, 0, 0, 1, 0));
        add(0, 0, 0, 0, pk(0, 0, 0, 0, 0));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        fs = 0; go = 0; win = 0; key = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), pk(0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        build_table();
        foreach (vecs[i]) begin
            fs  = vecs[i].fs;
            go  = vecs[i].go;
            win = vecs[i].win;
            key = vecs[i].key;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at vec%0d", i);
            end else begin
                check($sformatf("vec%0d", i), outs(), sb.pop_front());
            end
        end

        // Asynchronous reset in the middle of a fade.
        cyc(0, 1, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (7) cyc(1, 0, 0, 0);
        check("fade_at_7", outs(), pk(0, 1, 7, 0, 1));
        fs = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_midfade", outs(), pk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("held_in_reset", outs(), pk(0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 1, 0);
        check("game_over_after_reset", outs(), pk(0, 1, 0, 0, 1));
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("fade_restarts_after_reset", outs(), pk(0, 1, 1, 0, 1));
        cyc(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
